// File: rtl/id_stage.sv
// id_stage: RV decode with same-cycle regfile/CSR read, load-use interlock and a valid/ready output register
module id_stage #(
  parameter int XLEN = 32,
  parameter int M_EXT = 1,
  parameter int CSR_EXT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [4:0]      reg_raddr1_o,
  output logic [4:0]      reg_raddr2_o,
  input  logic [XLEN-1:0] reg_rdata1_i,
  input  logic [XLEN-1:0] reg_rdata2_i,
  output logic [11:0]     csr_raddr_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            flush_i,
  output logic            illegal_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_rdata_o
);
  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] addr;
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_rdata;
    logic            ill;
    logic            load;
  } out_t;
  out_t dec, out_d, out_q;
  logic out_valid_d, out_valid_q, pend_vld_d, pend_vld_q;
  logic [4:0] pend_rd_d, pend_rd_q;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic alu_i, alu_r, br, st, ld, jal, jalr, lui, auipc, csr, use1, use2, wr, ok;
  logic hazard, fire_in, fire_out;
  assign opc = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];
  assign alu_i = opc == 7'b0010011;
  assign alu_r = opc == 7'b0110011 && (f7 == 7'b0000000 || f7 == 7'b0100000 || (M_EXT != 0 && f7 == 7'b0000001));
  assign br = opc == 7'b1100011 && f3 != 3'b010 && f3 != 3'b011;
  assign st = opc == 7'b0100011 && f3 <= 3'b010;
  assign ld = opc == 7'b0000011 && (f3 <= 3'b010 || f3 == 3'b100 || f3 == 3'b101);
  assign jal = opc == 7'b1101111;
  assign jalr = opc == 7'b1100111 && f3 == 3'b000;
  assign lui = opc == 7'b0110111;
  assign auipc = opc == 7'b0010111;
  assign csr = CSR_EXT != 0 && opc == 7'b1110011 && f3[1:0] != 2'b00;
  assign use1 = alu_i || alu_r || br || st || ld || jalr || (csr && !f3[2]);
  assign use2 = alu_r || br || st;
  assign wr = alu_i || alu_r || ld || jal || jalr || lui || auipc || csr;
  assign ok = wr || br || st;
  // Read addresses are kept apart from the operand mux so the regfile read path is not a comb loop
  assign reg_raddr1_o = use1 ? inst_i[19:15] : 5'd0;
  assign reg_raddr2_o = use2 ? inst_i[24:20] : 5'd0;
  assign csr_raddr_o = csr ? inst_i[31:20] : 12'd0;
  always_comb begin
    dec = '0;
    dec.inst = inst_i;
    dec.addr = inst_addr_i;
    dec.ill = !ok;
    dec.load = ld;
    dec.we = wr;
    dec.waddr = wr ? inst_i[11:7] : 5'd0;
    dec.op1 = use1 ? reg_rdata1_i : (lui || auipc) ? XLEN'(signed'({inst_i[31:12], 12'b0})) : csr ? XLEN'(inst_i[19:15]) : '0;
    dec.op2 = use2 ? reg_rdata2_i : alu_i ? XLEN'(signed'(inst_i[31:20])) : auipc ? inst_addr_i : '0;
    dec.csr_we = csr;
    dec.csr_waddr = csr_raddr_o;
    dec.csr_rdata = csr ? csr_rdata_i : '0;
  end
  assign hazard = (out_valid_q && out_q.load && out_q.waddr != 5'd0 &&
                   (reg_raddr1_o == out_q.waddr || reg_raddr2_o == out_q.waddr)) ||
                  (pend_vld_q && (reg_raddr1_o == pend_rd_q || reg_raddr2_o == pend_rd_q));
  assign in_ready = !flush_i && !hazard && (!out_valid_q || out_ready);
  assign fire_in = in_valid && in_ready;
  assign fire_out = out_valid_q && out_ready;
  always_comb begin
    out_valid_d = flush_i ? 1'b0 : fire_in ? 1'b1 : fire_out ? 1'b0 : out_valid_q;
    pend_vld_d = !flush_i && fire_out && out_q.load && out_q.waddr != 5'd0;
    pend_rd_d = out_q.waddr;
    out_d = fire_in ? dec : out_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_rd_q <= '0;
      out_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pend_vld_q <= pend_vld_d;
      pend_rd_q <= pend_rd_d;
      out_q <= out_d;
    end
  end
  assign out_valid = out_valid_q;
  assign illegal_o = out_q.ill;
  assign inst_o = out_q.inst;
  assign inst_addr_o = out_q.addr;
  assign reg_we_o = out_q.we;
  assign reg_waddr_o = out_q.waddr;
  assign op1_o = out_q.op1;
  assign op2_o = out_q.op2;
  assign csr_we_o = out_q.csr_we;
  assign csr_waddr_o = out_q.csr_waddr;
  assign csr_rdata_o = out_q.csr_rdata;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random checks of id_stage against a rule-level decode and handshake model
module tb_id_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, out_valid, out_ready, flush_i, illegal;
  logic [31:0] inst_i, inst_addr_i, rdata1, rdata2, csr_rdata, inst_o, inst_addr_o, op1_o, op2_o, csr_rdata_o;
  logic [4:0] raddr1, raddr2, reg_waddr_o;
  logic [11:0] csr_raddr, csr_waddr_o;
  logic reg_we_o, csr_we_o;
  logic b_in_ready, b_out_valid, b_illegal, b_we, b_csr_we;
  logic [31:0] b_rdata1, b_rdata2, b_inst, b_addr, b_op1, b_op2, b_csr_rdata;
  logic [4:0] b_raddr1, b_raddr2, b_waddr;
  logic [11:0] b_csr_raddr, b_csr_waddr;
  logic [31:0] rf [32];
  int tests = 0, fails = 0;
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];
  assign b_rdata1 = rf[b_raddr1];
  assign b_rdata2 = rf[b_raddr2];
  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .reg_raddr1_o(raddr1), .reg_raddr2_o(raddr2), .reg_rdata1_i(rdata1), .reg_rdata2_i(rdata2),
    .csr_raddr_o(csr_raddr), .csr_rdata_i(csr_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .flush_i(flush_i), .illegal_o(illegal), .inst_o(inst_o), .inst_addr_o(inst_addr_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .op1_o(op1_o), .op2_o(op2_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_rdata_o(csr_rdata_o)
  );
  id_stage #(.XLEN(32), .M_EXT(0), .CSR_EXT(0)) dut_min (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .reg_raddr1_o(b_raddr1), .reg_raddr2_o(b_raddr2), .reg_rdata1_i(b_rdata1), .reg_rdata2_i(b_rdata2),
    .csr_raddr_o(b_csr_raddr), .csr_rdata_i(csr_rdata), .out_valid(b_out_valid), .out_ready(out_ready),
    .flush_i(flush_i), .illegal_o(b_illegal), .inst_o(b_inst), .inst_addr_o(b_addr), .reg_we_o(b_we),
    .reg_waddr_o(b_waddr), .op1_o(b_op1), .op2_o(b_op2), .csr_we_o(b_csr_we), .csr_waddr_o(b_csr_waddr),
    .csr_rdata_o(b_csr_rdata)
  );
  typedef struct packed {
    logic [31:0] inst, addr;
    logic we;
    logic [4:0] wa;
    logic [31:0] op1, op2;
    logic cwe;
    logic [11:0] cwa;
    logic [31:0] crd;
    logic ill, load;
    logic [4:0] ra1, ra2;
    logic [11:0] cra;
  } dec_t;
  dec_t m_s;
  bit m_v, m_pv, m_took;
  logic [4:0] m_prd;
  localparam logic [31:0] LW     = {12'd0, 5'd2, 3'b010, 5'd3, 7'h03};
  localparam logic [31:0] ADD1   = {7'h00, 5'd1, 5'd3, 3'b000, 5'd4, 7'h33};
  localparam logic [31:0] ADD_A  = {7'h00, 5'd2, 5'd1, 3'b000, 5'd5, 7'h33};
  localparam logic [31:0] ADD_B  = {7'h00, 5'd1, 5'd2, 3'b000, 5'd6, 7'h33};
  localparam logic [31:0] CSRRWI = {12'h300, 5'd5, 3'b101, 5'd1, 7'h73};
  localparam logic [31:0] MUL    = {7'h01, 5'd2, 5'd1, 3'b000, 5'd7, 7'h33};
  localparam logic [31:0] ADDI9  = {12'd7, 5'd1, 3'b000, 5'd9, 7'h13};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic dec_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] csr, input bit m, input bit c);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, u1, u2, w, ld, cs;
    logic [31:0] a, b;
    f3 = i[14:12];
    f7 = i[31:25];
    {ok, u1, u2, w, ld, cs} = '0;
    a = 0;
    b = 0;
    case (i[6:0])
      7'h13: begin ok = 1; u1 = 1; w = 1; b = {{20{i[31]}}, i[31:20]}; end
      7'h33: begin ok = f7 == 0 || f7 == 7'h20 || (m && f7 == 1); u1 = 1; u2 = 1; w = 1; end
      7'h63: begin ok = f3 != 2 && f3 != 3; u1 = 1; u2 = 1; end
      7'h23: begin ok = f3 < 3; u1 = 1; u2 = 1; end
      7'h03: begin ok = f3 != 3 && f3 < 6; u1 = 1; w = 1; ld = 1; end
      7'h6f: begin ok = 1; w = 1; end
      7'h67: begin ok = f3 == 0; u1 = 1; w = 1; end
      7'h37, 7'h17: begin ok = 1; w = 1; a = {i[31:12], 12'b0}; b = i[5] ? 32'd0 : pc; end
      7'h73: begin ok = c && f3[1:0] != 0; w = 1; cs = 1; u1 = !f3[2]; a = f3[2] ? {27'b0, i[19:15]} : 32'd0; end
      default: ;
    endcase
    d = '0;
    d.inst = i;
    d.addr = pc;
    if (!ok) begin
      d.ill = 1;
      return d;
    end
    d.ra1 = u1 ? i[19:15] : 5'd0;
    d.ra2 = u2 ? i[24:20] : 5'd0;
    if (u1) a = rf[d.ra1];
    if (u2) b = rf[d.ra2];
    d.we = w;
    d.wa = w ? i[11:7] : 5'd0;
    d.op1 = a;
    d.op2 = b;
    d.load = ld;
    if (cs) begin
      d.cwe = 1;
      d.cwa = i[31:20];
      d.cra = i[31:20];
      d.crd = csr;
    end
    return d;
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [11:0] im;
    logic [6:0] f7;
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom);
    im = 12'($urandom);
    f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : $urandom_range(0, 1) ? 7'h01 : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
    case ($urandom_range(0, 12))
      0: rand_inst = {im, r1, f3, rd, 7'h13};
      1: rand_inst = {f7, r2, r1, f3, rd, 7'h33};
      2: rand_inst = {im[11:5], r2, r1, f3, im[4:0], 7'h63};
      3: rand_inst = {im[11:5], r2, r1, f3, im[4:0], 7'h23};
      4, 5: rand_inst = {im, r1, f3, rd, 7'h03};
      6: rand_inst = {im, r1, f3, rd, 7'h6f};
      7: rand_inst = {im, r1, f3, rd, 7'h67};
      8: rand_inst = {im, r1, f3, rd, 7'h37};
      9: rand_inst = {im, r1, f3, rd, 7'h17};
      10: rand_inst = {im, r1, f3, rd, 7'h73};
      11: rand_inst = {f7, r2, r1, 3'b000, rd, 7'h33};
      default: rand_inst = $urandom;
    endcase
  endfunction
  // One clock: check outputs and in_ready against the model mid-cycle, then advance the model
  task automatic cycle();
    dec_t d;
    bit hz, rdy, drn;
    @(negedge clk);
    d = ref_dec(inst_i, inst_addr_i, csr_rdata, 1, 1);
    chk("out_valid", out_valid, m_v);
    chk("illegal_o", illegal, m_s.ill);
    chk("inst_o", inst_o, m_s.inst);
    chk("inst_addr_o", inst_addr_o, m_s.addr);
    chk("reg_we_o", reg_we_o, m_s.we);
    chk("reg_waddr_o", reg_waddr_o, m_s.wa);
    chk("op1_o", op1_o, m_s.op1);
    chk("op2_o", op2_o, m_s.op2);
    chk("csr_we_o", csr_we_o, m_s.cwe);
    chk("csr_waddr_o", csr_waddr_o, m_s.cwa);
    chk("csr_rdata_o", csr_rdata_o, m_s.crd);
    chk("reg_raddr1_o", raddr1, d.ra1);
    chk("reg_raddr2_o", raddr2, d.ra2);
    chk("csr_raddr_o", csr_raddr, d.cra);
    hz = (m_v && m_s.load && m_s.wa != 0 && (d.ra1 == m_s.wa || d.ra2 == m_s.wa)) ||
         (m_pv && (d.ra1 == m_prd || d.ra2 == m_prd));
    rdy = !flush_i && !hz && (!m_v || out_ready);
    chk("in_ready", in_ready, rdy);
    m_took = in_valid && rdy && !rst;
    drn = m_v && out_ready;
    if (rst) begin
      m_v = 0;
      m_s = '0;
      m_pv = 0;
      m_prd = 0;
    end else if (flush_i) begin
      m_v = 0;
      m_pv = 0;
    end else begin
      m_pv = drn && m_s.load && m_s.wa != 0;
      m_prd = m_s.wa;
      if (m_took) begin
        m_s = d;
        m_v = 1;
      end else if (drn) m_v = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n, bubbles;
    rst = 1;
    in_valid = 0;
    inst_i = 0;
    inst_addr_i = 0;
    out_ready = 1;
    flush_i = 0;
    csr_rdata = 0;
    foreach (rf[k]) rf[k] = $urandom;
    rf[0] = 0;
    rf[1] = 32'h10;
    m_v = 0;
    m_s = '0;
    m_pv = 0;
    m_prd = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    in_valid = 1;
    inst_i = 32'hFFF08293;
    inst_addr_i = 32'h1000;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("ready_after_reset", in_ready, 1'b1);
    cycle();
    in_valid = 0;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_waddr", reg_waddr_o, 5'd5);
    chk("addi_op1", op1_o, 32'h10);
    chk("addi_op2", op2_o, 32'hFFFFFFFF);
    chk("addi_we", reg_we_o, 1'b1);
    cycle();
    cycle();
    // load-use: ADD x4,x3,x1 behind LW x3
    inst_i = LW;
    in_valid = 1;
    cycle();
    inst_i = ADD1;
    m_took = 0;
    n = 0;
    bubbles = 0;
    while (!m_took && n < 10) begin
      bubbles += int'(!out_valid);
      cycle();
      n++;
    end
    chk("lu_add_valid", out_valid, 1'b1);
    chk("lu_add_inst", inst_o, ADD1);
    chk("lu_add_op1", op1_o, rf[3]);
    chk("lu_bubble", bubbles >= 1, 1'b1);
    in_valid = 0;
    cycle();
    cycle();
    // back-to-back with out_ready 1,0,1
    inst_i = ADD_A;
    in_valid = 1;
    cycle();
    inst_i = ADD_B;
    out_ready = 0;
    cycle();
    chk("stall_hold_valid", out_valid, 1'b1);
    chk("stall_hold_inst", inst_o, ADD_A);
    out_ready = 1;
    cycle();
    chk("after_stall_inst", inst_o, ADD_B);
    chk("after_stall_op1", op1_o, rf[2]);
    in_valid = 0;
    cycle();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_hold", inst_o, ADD_B);
    // CSRRWI x1, mstatus, 5 on both configurations
    inst_i = CSRRWI;
    csr_rdata = 32'hCAFE0001;
    in_valid = 1;
    cycle();
    in_valid = 0;
    chk("csr_we", csr_we_o, 1'b1);
    chk("csr_waddr", csr_waddr_o, 12'h300);
    chk("csr_op1", op1_o, 32'd5);
    chk("csr_rd_we", reg_we_o, 1'b1);
    chk("csr_rdata", csr_rdata_o, 32'hCAFE0001);
    chk("nocsr_valid", b_out_valid, 1'b1);
    chk("nocsr_illegal", b_illegal, 1'b1);
    chk("nocsr_csr_we", b_csr_we, 1'b0);
    chk("nocsr_csr_waddr", b_csr_waddr, 12'h0);
    chk("nocsr_op1", b_op1, 32'd0);
    chk("nocsr_we", b_we, 1'b0);
    inst_i = MUL;
    in_valid = 1;
    cycle();
    in_valid = 0;
    chk("mul_legal", illegal, 1'b0);
    chk("mul_we", reg_we_o, 1'b1);
    chk("mul_waddr", reg_waddr_o, 5'd7);
    chk("nomul_illegal", b_illegal, 1'b1);
    chk("nomul_we", b_we, 1'b0);
    chk("nomul_waddr", b_waddr, 5'd0);
    // flush while stalled
    inst_i = ADD_A;
    in_valid = 1;
    out_ready = 0;
    cycle();
    flush_i = 1;
    out_ready = 1;
    #1;
    chk("flush_ready", in_ready, 1'b0);
    cycle();
    flush_i = 0;
    chk("flush_valid", out_valid, 1'b0);
    // flush as a load leaves suppresses the pending bubble
    inst_i = LW;
    cycle();
    in_valid = 0;
    flush_i = 1;
    cycle();
    flush_i = 0;
    in_valid = 1;
    inst_i = ADD1;
    #1;
    chk("flush_clears_pend", in_ready, 1'b1);
    cycle();
    in_valid = 0;
    cycle();
    // reset with out_valid=1 and a pending load
    in_valid = 1;
    inst_i = LW;
    cycle();
    inst_i = ADDI9;
    cycle();
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1;
    out_ready = 0;
    in_valid = 0;
    cycle();
    rst = 0;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_addr", inst_addr_o, 32'd0);
    chk("rst_we", reg_we_o, 1'b0);
    chk("rst_waddr", reg_waddr_o, 5'd0);
    chk("rst_op1", op1_o, 32'd0);
    chk("rst_op2", op2_o, 32'd0);
    chk("rst_illegal", illegal, 1'b0);
    in_valid = 1;
    inst_i = ADD1;
    #1;
    chk("ready_after_rst", in_ready, 1'b1);
    cycle();
    out_ready = 1;
    in_valid = 0;
    cycle();
    for (int c = 0; c < 800; c++) begin
      rst = $urandom_range(0, 99) == 0;
      flush_i = $urandom_range(0, 19) == 0;
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      inst_i = rand_inst();
      inst_addr_i = $urandom;
      csr_rdata = $urandom;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
